// File: rtl/icache_4way_pkg.sv
// Shared definitions for the 4-way set-associative write-back cache.
// Holds bus widths, way count, the controller state encoding and a
// byte-merge helper used when a store hits a resident line.
package icache_4way_pkg;

  localparam int CacheAddrBus = 25;   // processor word address
  localparam int CacheDataBus = 32;   // processor data word
  localparam int CacheByteBus = 4;    // byte enables per word
  localparam int CacheLineBus = 128;  // one line = 4 words, word0 in [31:0]
  localparam int CacheWays    = 4;
  localparam int MemAddrBus   = 26;   // {line_addr, 3'b000}

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_COMPARE   = 2'd1,
    ST_WRITEBACK = 2'd2,
    ST_FILL      = 2'd3
  } cache_state_e;

  // Replace the bytes of old_word selected by byte_en with new_word.
  function automatic logic [CacheDataBus-1:0] merge_bytes(
    input logic [CacheDataBus-1:0] old_word,
    input logic [CacheDataBus-1:0] new_word,
    input logic [CacheByteBus-1:0] byte_en
  );
    logic [CacheDataBus-1:0] r;
    r = old_word;
    for (int b = 0; b < CacheByteBus; b++) begin
      if (byte_en[b]) r[8*b +: 8] = new_word[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/icache_4way_lru.sv
// True-LRU tracker for one 4-way set, kept as a pairwise age matrix.
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   touch_en      mark touch_way as most recently used this cycle
//   touch_way     way being touched
//   lru_way       current least recently used way
module icache_lru
  import icache_4way_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       touch_en,
  input  logic [1:0] touch_way,
  output logic [1:0] lru_way
);

  // older_q[i][j] = 1 means way i was used less recently than way j.
  // Reset order is way0 oldest ... way3 newest.
  localparam logic [CacheWays-1:0][CacheWays-1:0] OlderRst =
    '{4'b0000, 4'b1000, 4'b1100, 4'b1110};

  logic [CacheWays-1:0][CacheWays-1:0] older_q, older_d;

  always_comb begin
    older_d = older_q;
    if (touch_en) begin
      for (int j = 0; j < CacheWays; j++) begin
        if (j != int'(touch_way)) begin
          older_d[touch_way][j] = 1'b0;
          older_d[j][touch_way] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) older_q <= OlderRst;
    else      older_q <= older_d;
  end

  // The LRU way is older than every other way (diagonal is always 0,
  // so it is masked in with the way's own bit).
  always_comb begin
    lru_way = '0;
    for (int i = CacheWays - 1; i >= 0; i--) begin
      if (&(older_q[i] | (4'b0001 << i))) lru_way = 2'(i);
    end
  end

endmodule

// File: rtl/icache_4way.sv
// 4-way set-associative, write-back, write-allocate cache, 4 words/line.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   i_p_*/o_p_*              processor side, word addressed, one request
//                            in flight; o_p_waitrequest high when busy
//   o_m_*/i_m_*              128-bit line memory port (writeback + fill)
//   cnt_*                    read/write, hit and writeback statistics
module icache_4way
  import icache_4way_pkg::*;
#(
  parameter int cache_index = 2
)(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [CacheAddrBus-1:0] i_p_addr,
  input  logic [CacheByteBus-1:0] i_p_byte_en,
  input  logic [CacheDataBus-1:0] i_p_writedata,
  input  logic                    i_p_read,
  input  logic                    i_p_write,
  output logic [CacheDataBus-1:0] o_p_readdata,
  output logic                    o_p_readdata_valid,
  output logic                    o_p_waitrequest,
  output logic [MemAddrBus-1:0]   o_m_addr,
  output logic [3:0]              o_m_byte_en,
  output logic [CacheLineBus-1:0] o_m_writedata,
  output logic                    o_m_read,
  output logic                    o_m_write,
  input  logic [CacheLineBus-1:0] i_m_readdata,
  input  logic                    i_m_readdata_valid,
  input  logic                    i_m_waitrequest,
  output logic [31:0]             cnt_r,
  output logic [31:0]             cnt_w,
  output logic [31:0]             cnt_hit_r,
  output logic [31:0]             cnt_hit_w,
  output logic [31:0]             cnt_wb_r,
  output logic [31:0]             cnt_wb_w
);

  localparam int NumSets     = 1 << cache_index;
  localparam int TagBus      = CacheAddrBus - 2 - cache_index;
  localparam int LineAddrBus = CacheAddrBus - 2;

  cache_state_e state_q, state_d;
  logic [CacheAddrBus-1:0] req_addr_q, req_addr_d;
  logic [CacheDataBus-1:0] req_wdata_q, req_wdata_d;
  logic [CacheByteBus-1:0] req_be_q, req_be_d;
  logic                    req_wr_q, req_wr_d;
  logic                    first_q, first_d;    // first compare of this request
  logic [1:0]              victim_q, victim_d;
  logic [CacheDataBus-1:0] rdata_q, rdata_d;
  logic                    rvalid_q, rvalid_d;
  logic [NumSets-1:0][CacheWays-1:0] valid_q, valid_d, dirty_q, dirty_d;
  logic [31:0] cnt_r_q, cnt_r_d, cnt_w_q, cnt_w_d;
  logic [31:0] cnt_hit_r_q, cnt_hit_r_d, cnt_hit_w_q, cnt_hit_w_d;
  logic [31:0] cnt_wb_r_q, cnt_wb_r_d, cnt_wb_w_q, cnt_wb_w_d;

  // Tag and data storage need no reset: valid bits gate every use.
  logic [TagBus-1:0]       tag_mem  [NumSets][CacheWays];
  logic [CacheLineBus-1:0] line_mem [NumSets][CacheWays];

  logic                    line_we, tag_we;
  logic [1:0]              line_way;
  logic [CacheLineBus-1:0] line_wdata;

  // Request address decode
  logic [cache_index-1:0] req_set;
  logic [TagBus-1:0]      req_tag;
  logic [1:0]             req_word;
  assign req_set  = req_addr_q[cache_index+1:2];
  assign req_tag  = req_addr_q[CacheAddrBus-1:cache_index+2];
  assign req_word = req_addr_q[1:0];

  // Tag compare across the four ways of the addressed set
  logic [CacheWays-1:0]    hit_vec;
  logic                    hit;
  logic [1:0]              hit_way;
  logic [CacheLineBus-1:0] hit_line, merged_line;
  logic [CacheDataBus-1:0] hit_word;

  genvar gi;
  generate
    for (gi = 0; gi < CacheWays; gi++) begin : g_hit
      assign hit_vec[gi] = valid_q[req_set][gi] && (tag_mem[req_set][gi] == req_tag);
    end
  endgenerate

  always_comb begin
    hit_way = '0;
    for (int w = CacheWays - 1; w >= 0; w--) begin
      if (hit_vec[w]) hit_way = 2'(w);
    end
  end

  assign hit      = |hit_vec;
  assign hit_line = line_mem[req_set][hit_way];
  assign hit_word = hit_line[{req_word, 5'b00000} +: CacheDataBus];

  always_comb begin
    merged_line = hit_line;
    merged_line[{req_word, 5'b00000} +: CacheDataBus] =
      merge_bytes(hit_word, req_wdata_q, req_be_q);
  end

  // One LRU tracker per set; only the addressed set is touched on a hit.
  logic [1:0]         lru_way_arr [NumSets];
  logic               lru_touch;
  logic [NumSets-1:0] set_onehot;
  assign set_onehot = {{(NumSets-1){1'b0}}, 1'b1} << req_set;

  generate
    for (gi = 0; gi < NumSets; gi++) begin : g_lru
      icache_lru u_lru (
        .clk       (clk),
        .rst       (rst),
        .touch_en  (lru_touch & set_onehot[gi]),
        .touch_way (hit_way),
        .lru_way   (lru_way_arr[gi])
      );
    end
  endgenerate

  // Victim: lowest-index invalid way, otherwise the set's LRU way.
  logic [1:0] victim_sel;
  always_comb begin
    victim_sel = lru_way_arr[req_set];
    for (int w = CacheWays - 1; w >= 0; w--) begin
      if (!valid_q[req_set][w]) victim_sel = 2'(w);
    end
  end

  logic [LineAddrBus-1:0] wb_line_addr, fill_line_addr;
  assign wb_line_addr   = {tag_mem[req_set][victim_q], req_set};
  assign fill_line_addr = req_addr_q[CacheAddrBus-1:2];

  // Controller
  always_comb begin
    state_d     = state_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    req_be_d    = req_be_q;
    req_wr_d    = req_wr_q;
    first_d     = first_q;
    victim_d    = victim_q;
    rdata_d     = rdata_q;
    rvalid_d    = 1'b0;
    valid_d     = valid_q;
    dirty_d     = dirty_q;
    cnt_r_d     = cnt_r_q;
    cnt_w_d     = cnt_w_q;
    cnt_hit_r_d = cnt_hit_r_q;
    cnt_hit_w_d = cnt_hit_w_q;
    cnt_wb_r_d  = cnt_wb_r_q;
    cnt_wb_w_d  = cnt_wb_w_q;
    line_we     = 1'b0;
    tag_we      = 1'b0;
    line_way    = hit_way;
    line_wdata  = merged_line;
    lru_touch   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_p_read || i_p_write) begin
          req_addr_d  = i_p_addr;
          req_wdata_d = i_p_writedata;
          req_be_d    = i_p_byte_en;
          req_wr_d    = ~i_p_read;  // read wins when both are raised
          first_d     = 1'b1;
          if (i_p_read) cnt_r_d = cnt_r_q + 32'd1;
          else          cnt_w_d = cnt_w_q + 32'd1;
          state_d = ST_COMPARE;
        end
      end

      ST_COMPARE: begin
        first_d = 1'b0;
        if (hit) begin
          lru_touch = 1'b1;
          if (req_wr_q) begin
            line_we = 1'b1;
            dirty_d[req_set][hit_way] = 1'b1;
            if (first_q) cnt_hit_w_d = cnt_hit_w_q + 32'd1;
          end else begin
            rdata_d  = hit_word;
            rvalid_d = 1'b1;
            if (first_q) cnt_hit_r_d = cnt_hit_r_q + 32'd1;
          end
          state_d = ST_IDLE;
        end else begin
          victim_d = victim_sel;
          if (valid_q[req_set][victim_sel] && dirty_q[req_set][victim_sel]) begin
            if (req_wr_q) cnt_wb_w_d = cnt_wb_w_q + 32'd1;
            else          cnt_wb_r_d = cnt_wb_r_q + 32'd1;
            state_d = ST_WRITEBACK;
          end else begin
            state_d = ST_FILL;
          end
        end
      end

      ST_WRITEBACK: begin
        if (!i_m_waitrequest) state_d = ST_FILL;
      end

      ST_FILL: begin
        if (i_m_readdata_valid) begin
          line_we    = 1'b1;
          tag_we     = 1'b1;
          line_way   = victim_q;
          line_wdata = i_m_readdata;
          valid_d[req_set][victim_q] = 1'b1;
          dirty_d[req_set][victim_q] = 1'b0;
          state_d = ST_COMPARE;  // re-compare now hits and finishes the request
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_be_q    <= '0;
      req_wr_q    <= 1'b0;
      first_q     <= 1'b0;
      victim_q    <= '0;
      rdata_q     <= '0;
      rvalid_q    <= 1'b0;
      valid_q     <= '0;
      dirty_q     <= '0;
      cnt_r_q     <= '0;
      cnt_w_q     <= '0;
      cnt_hit_r_q <= '0;
      cnt_hit_w_q <= '0;
      cnt_wb_r_q  <= '0;
      cnt_wb_w_q  <= '0;
    end else begin
      state_q     <= state_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      req_be_q    <= req_be_d;
      req_wr_q    <= req_wr_d;
      first_q     <= first_d;
      victim_q    <= victim_d;
      rdata_q     <= rdata_d;
      rvalid_q    <= rvalid_d;
      valid_q     <= valid_d;
      dirty_q     <= dirty_d;
      cnt_r_q     <= cnt_r_d;
      cnt_w_q     <= cnt_w_d;
      cnt_hit_r_q <= cnt_hit_r_d;
      cnt_hit_w_q <= cnt_hit_w_d;
      cnt_wb_r_q  <= cnt_wb_r_d;
      cnt_wb_w_q  <= cnt_wb_w_d;
    end
  end

  always_ff @(posedge clk) begin
    if (line_we) line_mem[req_set][line_way] <= line_wdata;
    if (tag_we)  tag_mem[req_set][victim_q]  <= req_tag;
  end

  // Memory port is driven straight from the state so a reset drops it at once.
  always_comb begin
    o_m_addr      = '0;
    o_m_writedata = '0;
    case (state_q)
      ST_WRITEBACK: begin
        o_m_addr      = {wb_line_addr, 3'b000};
        o_m_writedata = line_mem[req_set][victim_q];
      end
      ST_FILL: o_m_addr = {fill_line_addr, 3'b000};
      default: ;
    endcase
  end

  assign o_m_read           = (state_q == ST_FILL);
  assign o_m_write          = (state_q == ST_WRITEBACK);
  assign o_m_byte_en        = 4'b1111;
  assign o_p_waitrequest    = (state_q != ST_IDLE);
  assign o_p_readdata       = rdata_q;
  assign o_p_readdata_valid = rvalid_q;
  assign cnt_r              = cnt_r_q;
  assign cnt_w              = cnt_w_q;
  assign cnt_hit_r          = cnt_hit_r_q;
  assign cnt_hit_w          = cnt_hit_w_q;
  assign cnt_wb_r           = cnt_wb_r_q;
  assign cnt_wb_w           = cnt_wb_w_q;

endmodule

// File: tb/tb_icache_4way.sv
module tb_icache_4way;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [24:0]  i_p_addr = '0;
  logic [3:0]   i_p_byte_en = '0;
  logic [31:0]  i_p_writedata = '0;
  logic         i_p_read = 1'b0;
  logic         i_p_write = 1'b0;
  logic [31:0]  o_p_readdata;
  logic         o_p_readdata_valid;
  logic         o_p_waitrequest;
  logic [25:0]  o_m_addr;
  logic [3:0]   o_m_byte_en;
  logic [127:0] o_m_writedata;
  logic         o_m_read;
  logic         o_m_write;
  logic [127:0] i_m_readdata = '0;
  logic         i_m_readdata_valid = 1'b0;
  logic         i_m_waitrequest = 1'b1;
  logic [31:0]  cnt_r, cnt_w, cnt_hit_r, cnt_hit_w, cnt_wb_r, cnt_wb_w;

  always #5 clk = ~clk;

  icache_4way #(.cache_index(2)) dut (
    .clk(clk), .rst(rst),
    .i_p_addr(i_p_addr), .i_p_byte_en(i_p_byte_en), .i_p_writedata(i_p_writedata),
    .i_p_read(i_p_read), .i_p_write(i_p_write),
    .o_p_readdata(o_p_readdata), .o_p_readdata_valid(o_p_readdata_valid),
    .o_p_waitrequest(o_p_waitrequest),
    .o_m_addr(o_m_addr), .o_m_byte_en(o_m_byte_en), .o_m_writedata(o_m_writedata),
    .o_m_read(o_m_read), .o_m_write(o_m_write),
    .i_m_readdata(i_m_readdata), .i_m_readdata_valid(i_m_readdata_valid),
    .i_m_waitrequest(i_m_waitrequest),
    .cnt_r(cnt_r), .cnt_w(cnt_w), .cnt_hit_r(cnt_hit_r), .cnt_hit_w(cnt_hit_w),
    .cnt_wb_r(cnt_wb_r), .cnt_wb_w(cnt_wb_w)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Backing memory: written-back lines are kept, all others follow a pattern
  // where word k of line L reads 0xD0000000 | L<<4 | k.
  logic [127:0] mem [int unsigned];
  int           rd_lat = 2;     // FILL cycles before data returns
  int           wb_wait = 0;    // cycles of waitrequest per writeback
  int           rd_hold = 0, wb_hold = 0;
  int           fill_cnt = 0, wb_cnt = 0, wb_stall = 0, wb_unstable = 0, overlap = 0;
  logic [25:0]  fill_addr_last = '0, wb_addr_last = '0, wb_addr_first = '0;
  logic [127:0] wb_data_last = '0;

  function automatic logic [31:0] pat(input logic [22:0] l, input int k);
    return 32'hD000_0000 | {5'b0, l, 4'b0} | 32'(k);
  endfunction

  function automatic logic [127:0] mem_line(input logic [22:0] l);
    if (mem.exists(32'(l))) return mem[32'(l)];
    return {pat(l, 3), pat(l, 2), pat(l, 1), pat(l, 0)};
  endfunction

  always @(negedge clk) begin
    i_m_readdata_valid = 1'b0;
    i_m_waitrequest    = 1'b1;
    if (o_m_read && o_m_write) overlap++;
    if (o_m_write) begin
      if (wb_hold == 0) wb_addr_first = o_m_addr;
      else if (o_m_addr != wb_addr_first) wb_unstable++;
      if (wb_hold < wb_wait) begin
        wb_hold++;
        wb_stall++;
      end else begin
        i_m_waitrequest = 1'b0;
        mem[32'(o_m_addr[25:3])] = o_m_writedata;
        wb_addr_last = o_m_addr;
        wb_data_last = o_m_writedata;
        wb_cnt++;
        wb_hold = 0;
      end
    end else begin
      wb_hold = 0;
    end
    if (o_m_read) begin
      rd_hold++;
      if (rd_hold >= rd_lat) begin
        i_m_readdata_valid = 1'b1;
        i_m_readdata       = mem_line(o_m_addr[25:3]);
        fill_addr_last     = o_m_addr;
        fill_cnt++;
        rd_hold = 0;
      end
    end else begin
      rd_hold = 0;
    end
  end

  // One processor transaction; lat counts cycles from the accept edge to
  // the readdata strobe (reads) or to the return of waitrequest low (writes).
  task automatic cpu_op(input bit wr, input logic [24:0] a, input logic [31:0] wd,
                        input logic [3:0] be, output logic [31:0] rd, output int lat);
    int n;
    rd = '0;
    @(negedge clk);
    i_p_addr = a; i_p_writedata = wd; i_p_byte_en = be;
    i_p_read = !wr; i_p_write = wr;
    n = 0;
    while (o_p_waitrequest && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    i_p_read = 1'b0; i_p_write = 1'b0;
    lat = 1;
    if (!wr) begin
      while (!o_p_readdata_valid && lat < 300) begin
        @(negedge clk);
        lat++;
      end
      check_val("rd_done", {127'b0, o_p_readdata_valid}, 128'd1);
      rd = o_p_readdata;
      $display("rd addr=%07h data=%08h lat=%0d", a, rd, lat);
    end else begin
      while (o_p_waitrequest && lat < 300) begin
        @(negedge clk);
        lat++;
      end
      check_val("wr_done", {127'b0, o_p_waitrequest}, 128'd0);
      $display("wr addr=%07h data=%08h be=%04b lat=%0d", a, wd, be, lat);
    end
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    logic [31:0] rd;
    int lat, f0, w0, s0, n;

    // Reset state
    repeat (2) @(negedge clk);
    check_val("rst_waitreq", o_p_waitrequest, 0);
    check_val("rst_rvalid", o_p_readdata_valid, 0);
    check_val("rst_m_read", o_m_read, 0);
    check_val("rst_m_write", o_m_write, 0);
    check_val("rst_m_addr", o_m_addr, 0);
    check_val("rst_m_wdata", o_m_writedata, 0);
    check_val("rst_cnt_r", cnt_r, 0);
    @(negedge clk);
    rst = 1'b1;

    // Cold miss, then hits in the same line
    f0 = fill_cnt;
    cpu_op(0, 25'h4, 32'h0, 4'h0, rd, lat);
    check_val("cold_data", rd, 32'hD000_0010);
    check_val("cold_fills", fill_cnt - f0, 1);
    check_val("cold_maddr", fill_addr_last, 26'h8);
    f0 = fill_cnt;
    cpu_op(0, 25'h5, 32'h0, 4'h0, rd, lat);
    check_val("hit_data", rd, 32'hD000_0011);
    check_val("hit_lat", lat, 2);
    check_val("hit_nofill", fill_cnt - f0, 0);
    check_val("hit_cnt_r", cnt_r, 2);
    check_val("hit_cnt_hit_r", cnt_hit_r, 1);

    // Partial write hit and read back
    cpu_op(1, 25'h5, 32'hAABB_CCDD, 4'b0011, rd, lat);
    check_val("wr_cnt_w", cnt_w, 1);
    check_val("wr_cnt_hit_w", cnt_hit_w, 1);
    cpu_op(0, 25'h5, 32'h0, 4'h0, rd, lat);
    check_val("wr_merge", rd, 32'hD000_CCDD);
    check_val("wr_merge_lat", lat, 2);

    // Fill set 0, touch way0, then evict the LRU way (clean)
    f0 = fill_cnt;
    cpu_op(0, 25'h00, 32'h0, 4'h0, rd, lat);
    cpu_op(0, 25'h10, 32'h0, 4'h0, rd, lat);
    cpu_op(0, 25'h20, 32'h0, 4'h0, rd, lat);
    cpu_op(0, 25'h30, 32'h0, 4'h0, rd, lat);
    check_val("set0_fills", fill_cnt - f0, 4);
    cpu_op(1, 25'h00, 32'h1122_3344, 4'hF, rd, lat);
    w0 = wb_cnt; f0 = fill_cnt;
    cpu_op(0, 25'h40, 32'h0, 4'h0, rd, lat);
    check_val("evict_data", rd, 32'hD000_0100);
    check_val("evict_maddr", fill_addr_last, 26'h80);
    check_val("evict_no_wb", wb_cnt - w0, 0);
    check_val("evict_fill", fill_cnt - f0, 1);
    f0 = fill_cnt;
    cpu_op(0, 25'h10, 32'h0, 4'h0, rd, lat);
    check_val("evicted_miss", fill_cnt - f0, 1);
    check_val("evicted_data", rd, 32'hD000_0040);
    cpu_op(0, 25'h00, 32'h0, 4'h0, rd, lat);
    check_val("dirty_kept", rd, 32'h1122_3344);
    check_val("dirty_kept_lat", lat, 2);
    check_val("set0_cnt_wb_r", cnt_wb_r, 0);

    // Dirty eviction with a stalled writeback
    reset_dut();
    wb_wait = 5;
    cpu_op(1, 25'h00, 32'h1122_3344, 4'hF, rd, lat);
    cpu_op(0, 25'h10, 32'h0, 4'h0, rd, lat);
    cpu_op(0, 25'h20, 32'h0, 4'h0, rd, lat);
    cpu_op(0, 25'h30, 32'h0, 4'h0, rd, lat);
    s0 = wb_stall; w0 = wb_cnt; f0 = fill_cnt;
    cpu_op(0, 25'h40, 32'h0, 4'h0, rd, lat);
    check_val("wb_count", wb_cnt - w0, 1);
    check_val("wb_addr", wb_addr_last, 26'h0);
    check_val("wb_data", wb_data_last, 128'hD0000003_D0000002_D0000001_11223344);
    check_val("wb_stall", wb_stall - s0, 5);
    check_val("wb_addr_stable", wb_unstable, 0);
    check_val("wb_no_overlap", overlap, 0);
    check_val("wb_then_fill", fill_cnt - f0, 1);
    check_val("wb_fill_addr", fill_addr_last, 26'h80);
    check_val("wb_fill_data", rd, 32'hD000_0100);
    check_val("wb_byte_en", o_m_byte_en, 4'hF);
    check_val("wb_cnt_wb_r", cnt_wb_r, 1);
    check_val("wb_cnt_wb_w", cnt_wb_w, 0);
    check_val("wb_cnt_w", cnt_w, 1);
    check_val("wb_cnt_hit_w", cnt_hit_w, 0);
    check_val("wb_cnt_r", cnt_r, 4);
    wb_wait = 0;
    f0 = fill_cnt;
    cpu_op(0, 25'h00, 32'h0, 4'h0, rd, lat);
    check_val("refetch_miss", fill_cnt - f0, 1);
    check_val("refetch_data", rd, 32'h1122_3344);

    // Reset asserted in the middle of a fill
    rd_lat = 20;
    @(negedge clk);
    i_p_addr = 25'h8; i_p_read = 1'b1;
    @(negedge clk);
    i_p_read = 1'b0;
    n = 0;
    while (!o_m_read && n < 10) begin
      @(negedge clk);
      n++;
    end
    check_val("abort_in_fill", o_m_read, 1);
    #2 rst = 1'b0;
    #1;
    check_val("abort_m_read", o_m_read, 0);
    check_val("abort_m_addr", o_m_addr, 0);
    check_val("abort_waitreq", o_p_waitrequest, 0);
    check_val("abort_cnt_r", cnt_r, 0);
    @(negedge clk);
    rst = 1'b1;
    rd_lat = 2;
    f0 = fill_cnt;
    cpu_op(0, 25'h8, 32'h0, 4'h0, rd, lat);
    check_val("abort_remiss", fill_cnt - f0, 1);
    check_val("abort_data", rd, 32'hD000_0020);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
